// File: rtl/karatsuba_mul_arbiter.sv
// karatsuba_mul_arbiter
// Shares a single 256x256 multiplier (start/done handshake, 512-bit product)
// between NUM_REQ requesters. Round-robin grant, operand latch, one-cycle
// start pulse, done capture with a watchdog abort, and a held response that
// carries the owning requester id.
//
// Handshakes: a transfer happens in any cycle where valid and ready are both
// high at the rising clock edge; valid never depends on ready, and a
// presented response (rsp_valid/rsp_id/rsp_p/rsp_err) stays stable until it
// is taken.
module karatsuba_mul_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [NUM_REQ*256-1:0] req_a,
   input  logic [NUM_REQ*256-1:0] req_b,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [511:0]           rsp_p,
   output logic                   rsp_err,
   output logic                   mul_start,
   output logic [255:0]           mul_a,
   output logic [255:0]           mul_b,
   input  logic [511:0]           mul_p,
   input  logic                   mul_done,
   output logic                   busy,
   output logic [1:0]             dbg_state_o
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [255:0]      a_q, a_d;
   logic [255:0]      b_q, b_d;
   logic [WD_W-1:0]   wdog_q, wdog_d;
   logic [511:0]      rsp_p_q, rsp_p_d;
   logic              rsp_err_q, rsp_err_d;

   logic              grant_found;
   logic [ID_W-1:0]   grant_id;
   logic [ID_W:0]     idx;

   // Round-robin pick: first valid requester after the pointer, wrapping.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      idx         = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = {1'b0, ptr_q} + (ID_W+1)'(k);
         if (idx >= (ID_W+1)'(NUM_REQ)) begin
            idx = idx - (ID_W+1)'(NUM_REQ);
         end
         if (!grant_found && req_valid[idx[ID_W-1:0]]) begin
            grant_found = 1'b1;
            grant_id    = idx[ID_W-1:0];
         end
      end
   end

   // Next-state logic, grant, operand latch, watchdog and result capture.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      id_d      = id_q;
      a_d       = a_q;
      b_d       = b_q;
      wdog_d    = wdog_q;
      rsp_p_d   = rsp_p_q;
      rsp_err_d = rsp_err_q;
      req_ready = '0;
      case (state_q)
         S_IDLE: begin
            // Ready is only raised towards a valid requester, so a raised
            // ready always completes a transfer at the next edge.
            if (grant_found && !reset) begin
               req_ready = NUM_REQ'(1) << grant_id;
               ptr_d     = grant_id;
               id_d      = grant_id;
               a_d       = req_a[256*grant_id +: 256];
               b_d       = req_b[256*grant_id +: 256];
               state_d   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            wdog_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            wdog_d = wdog_q + WD_W'(1);
            // A completion in the last allowed cycle still counts as success.
            if (mul_done) begin
               rsp_p_d   = mul_p;
               rsp_err_d = 1'b0;
               state_d   = S_RESP;
            end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
               rsp_p_d   = '0;
               rsp_err_d = 1'b1;
               state_d   = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any job in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         ptr_q     <= ID_W'(NUM_REQ - 1);
         id_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         wdog_q    <= '0;
         rsp_p_q   <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         id_q      <= id_d;
         a_q       <= a_d;
         b_q       <= b_d;
         wdog_q    <= wdog_d;
         rsp_p_q   <= rsp_p_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   assign mul_start   = (state_q == S_ISSUE);
   assign mul_a       = a_q;
   assign mul_b       = b_q;
   assign rsp_valid   = (state_q == S_RESP);
   assign rsp_id      = id_q;
   assign rsp_p       = rsp_p_q;
   assign rsp_err     = rsp_err_q;
   assign busy        = (state_q != S_IDLE);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_karatsuba_mul_arbiter.sv
// Bench for karatsuba_mul_arbiter: a multiplier stub with fixed latency (and
// a hang mode), randomized requesters, a round-robin reference model and a
// response scoreboard.
module tb_karatsuba_mul_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int TIMEOUT = 16;
   localparam int MUL_LAT = 7;
   localparam int EW      = 1 + ID_W + 512;

   logic                   clock = 1'b0;
   logic                   reset;
   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ*256-1:0] req_a;
   logic [NUM_REQ*256-1:0] req_b;
   logic [NUM_REQ-1:0]     req_ready;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [ID_W-1:0]        rsp_id;
   logic [511:0]           rsp_p;
   logic                   rsp_err;
   logic                   mul_start;
   logic [255:0]           mul_a;
   logic [255:0]           mul_b;
   logic [511:0]           mul_p;
   logic                   mul_done;
   logic                   busy;
   logic [1:0]             dbg_state;

   karatsuba_mul_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_p(rsp_p),
      .rsp_err(rsp_err), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
      .mul_p(mul_p), .mul_done(mul_done), .busy(busy), .dbg_state_o(dbg_state)
   );

   // ---------------- clock / reset / bookkeeping ----------------
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- multiplier stub ----------------
   logic         hang = 1'b0;
   int           stub_cnt = 0;
   logic [511:0] stub_p = '0;
   always @(posedge clock) begin
      if (reset) begin
         stub_cnt <= 0;
      end else if (mul_start) begin
         stub_cnt <= MUL_LAT;
         stub_p   <= {256'b0, mul_a} * {256'b0, mul_b};
      end else if (stub_cnt > 0) begin
         stub_cnt <= stub_cnt - 1;
      end
   end
   assign mul_done = (stub_cnt == 1) && !hang;
   assign mul_p    = stub_p;

   // ---------------- reference model + scoreboard ----------------
   logic [EW-1:0] exp_q[$];
   int            acc_q[$];
   int            grant_log[$];
   int            acc_cnt[NUM_REQ];
   bit            m_free = 1'b1;
   int            m_ptr = NUM_REQ - 1;
   int            start_due = -1;
   bit            rsp_seen = 1'b0;
   logic [EW-1:0] cur_e;
   logic [255:0]  cur_a, cur_b;

   initial for (int i = 0; i < NUM_REQ; i++) acc_cnt[i] = 0;

   always @(negedge clock) begin
      int g;
      int idx;
      int lat;
      logic [NUM_REQ-1:0] exp_rdy;
      logic [511:0] pe;
      if (reset) begin
         m_free    = 1'b1;
         m_ptr     = NUM_REQ - 1;
         start_due = -1;
         rsp_seen  = 1'b0;
         exp_q.delete();
         acc_q.delete();
      end else begin
         chk("busy", busy, !m_free);
         g = -1;
         if (m_free) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
               idx = (m_ptr + k) % NUM_REQ;
               if (g < 0 && req_valid[idx]) g = idx;
            end
         end
         exp_rdy = '0;
         if (g >= 0) exp_rdy[g] = 1'b1;
         chk("req_ready", req_ready, exp_rdy);
         if (g >= 0) begin
            acc_cnt[g]++;
            m_ptr  = g;
            m_free = 1'b0;
            grant_log.push_back(g);
            cur_a = req_a[256*g +: 256];
            cur_b = req_b[256*g +: 256];
            pe    = hang ? 512'b0 : ({256'b0, cur_a} * {256'b0, cur_b});
            exp_q.push_back({hang, ID_W'(g), pe});
            acc_q.push_back(cyc);
            start_due = cyc + 1;
         end
         chk("mul_start", mul_start, cyc == start_due);
         if (cyc == start_due) begin
            chk("mul_a", mul_a, cur_a);
            chk("mul_b", mul_b, cur_b);
         end
         if (rsp_valid) begin
            if (!rsp_seen) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL rsp_unexpected at cycle %0d: got rsp_valid=1 expected no response", cyc);
                  cur_e = {rsp_err, rsp_id, rsp_p};
               end else begin
                  cur_e = exp_q.pop_front();
                  lat   = cyc - acc_q.pop_front();
                  if (cur_e[EW-1]) chk("err_latency_in_window", (lat >= TIMEOUT + 1) && (lat <= TIMEOUT + 2), 1'b1);
                  else chk("latency", lat, 9);
               end
            end
            chk("rsp_id", rsp_id, cur_e[512 +: ID_W]);
            chk("rsp_p", rsp_p, cur_e[511:0]);
            chk("rsp_err", rsp_err, cur_e[EW-1]);
            rsp_seen = 1'b1;
            if (rsp_ready) begin
               rsp_seen = 1'b0;
               m_free   = 1'b1;
            end
         end
      end
   end

   // ---------------- driver ----------------
   logic         vld[NUM_REQ];
   logic [255:0] op_a[NUM_REQ];
   logic [255:0] op_b[NUM_REQ];
   int           seen[NUM_REQ];
   bit           auto_refill = 1'b0;

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
      return r;
   endfunction

   function automatic bit vld_none();
      for (int i = 0; i < NUM_REQ; i++) if (vld[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic drive_bus();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_valid[i]       = vld[i];
         req_a[256*i +: 256] = op_a[i];
         req_b[256*i +: 256] = op_b[i];
      end
   endtask

   task automatic load(input int p, input logic [255:0] a, input logic [255:0] b);
      vld[p]  = 1'b1;
      op_a[p] = a;
      op_b[p] = b;
      drive_bus();
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (acc_cnt[i] != seen[i]) begin
            seen[i] = acc_cnt[i];
            if (auto_refill) begin
               op_a[i] = rand256();
               op_b[i] = rand256();
            end else begin
               vld[i] = 1'b0;
            end
         end
      end
      drive_bus();
   endtask

   task automatic drain(input int budget);
      int n = 0;
      rsp_ready = 1'b1;
      while (!(vld_none() && m_free && exp_q.size() == 0) && n < budget) begin
         step();
         n++;
      end
      if (n >= budget) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout at cycle %0d: got no idle after %0d cycles expected idle", cyc, budget);
      end
   endtask

   task automatic reset_checks();
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_mul_start", mul_start, 1'b0);
      chk("rst_req_ready", req_ready, '0);
      chk("rst_rsp_err", rsp_err, 1'b0);
      chk("rst_rsp_id", rsp_id, '0);
      chk("rst_rsp_p", rsp_p, '0);
      chk("rst_mul_a", mul_a, '0);
      chk("rst_mul_b", mul_b, '0);
   endtask

   task automatic apply_reset();
      for (int i = 0; i < NUM_REQ; i++) vld[i] = 1'b0;
      drive_bus();
      reset = 1'b1;
      step();
      step();
      reset_checks();
      reset = 1'b0;
      step();
   endtask

   initial begin
      int base;
      int n;
      logic [255:0] ones;
      reset     = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
         vld[i] = 1'b0; op_a[i] = '0; op_b[i] = '0; seen[i] = 0;
      end
      drive_bus();
      apply_reset();

      // Single requester on port 2: 3 * 5.
      load(2, 256'd3, 256'd5);
      drain(100);

      // All ports held valid from reset: grants rotate 0,1,2,3,0,1.
      apply_reset();
      base = grant_log.size();
      auto_refill = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) load(i, rand256(), rand256());
      n = 0;
      while (grant_log.size() < base + 6 && n < 200) begin step(); n++; end
      auto_refill = 1'b0;
      drain(200);
      if (grant_log.size() >= base + 6) begin
         for (int i = 0; i < 6; i++) chk("grant_order", grant_log[base + i], i % NUM_REQ);
      end else begin
         checks++;
         errors++;
         $display("FAIL grant_order: got %0d grants expected 6", grant_log.size() - base);
      end

      // Consumer stalls for 5 cycles while other requesters wait.
      rsp_ready = 1'b0;
      load(0, rand256(), rand256());
      load(3, rand256(), rand256());
      n = 0;
      while (!rsp_valid && n < 50) begin step(); n++; end
      repeat (5) step();
      drain(200);

      // Largest operands.
      ones = '1;
      load(1, ones, ones);
      drain(100);

      // Multiplier never completes: watchdog abort, then a normal job.
      hang = 1'b1;
      load(0, rand256(), rand256());
      drain(100);
      hang = 1'b0;
      load(2, rand256(), rand256());
      drain(100);

      // Random traffic with a randomly stalling consumer.
      for (int it = 0; it < 150; it++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!vld[i] && $urandom_range(0, 3) == 0) load(i, rand256(), rand256());
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      drain(400);

      // Reset while waiting on the multiplier: the job is dropped.
      apply_reset();
      load(1, rand256(), rand256());
      load(3, rand256(), rand256());
      n = 0;
      while (m_free && n < 20) begin step(); n++; end
      repeat (3) step();
      reset = 1'b1;
      step();
      reset_checks();
      load(1, rand256(), rand256());
      load(3, rand256(), rand256());
      base = grant_log.size();
      reset = 1'b0;
      drain(200);
      if (grant_log.size() > base) chk("grant_after_reset", grant_log[base], 1);
      else begin
         checks++;
         errors++;
         $display("FAIL grant_after_reset: got no grant expected port 1");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: got no finish expected finish before time limit");
      $fatal(1, "time limit");
   end

endmodule
